// File: rtl/dmem_arb_pkg.sv
// ----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and defaults for the data-RAM arbiter.
//   owner_t           : which master owns a RAM slot / pending read data
//   DEFAULT_MAX_BURST : default cap on locked DMA grants while the CPU waits
//   cnt_w()           : width of a counter that must hold 0..max inclusive
// ----------------------------------------------------------------------------
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    localparam int DEFAULT_MAX_BURST = 8;

    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// ----------------------------------------------------------------------------
// dmem_arb_pick
// Combinational winner select for the shared data-RAM port.
// Ports:
//   cpu_elig_i  : CPU request that is not waiting on its own read data
//   dma_req_i   : DMA request
//   lock_act_i  : DMA held dma_lock on its previous grant and still holds it
//   burst_cnt_i : locked DMA grants issued while the CPU has been waiting
//   rr_last_i   : master granted most recently
//   win_o       : owner of this cycle's RAM slot
// Build option: ARB_ROUND_ROBIN_EN selects alternating priority on unlocked
// conflicts; otherwise the CPU always wins an unlocked conflict.
// ----------------------------------------------------------------------------
module dmem_arb_pick import dmem_arb_pkg::*; #(
    parameter int MAX_BURST = DEFAULT_MAX_BURST,
    parameter int CW        = cnt_w(MAX_BURST)
) (
    input  logic          cpu_elig_i,
    input  logic          dma_req_i,
    input  logic          lock_act_i,
    input  logic [CW-1:0] burst_cnt_i,
    input  owner_t        rr_last_i,
    output owner_t        win_o
);

    localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);

`ifndef ARB_ROUND_ROBIN_EN
    // Fixed priority never consults the round-robin history.
    logic unused_rr;
    assign unused_rr = ^rr_last_i;
`endif

    always_comb begin
        win_o = OWN_NONE;
        // A locked burst keeps the port until it has starved the CPU MAX_BURST times.
        if (dma_req_i && lock_act_i && (burst_cnt_i < MAXC)) begin
            win_o = OWN_DMA;
        end else if (cpu_elig_i && dma_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
            win_o = (rr_last_i == OWN_CPU) ? OWN_DMA : OWN_CPU;
`else
            win_o = OWN_CPU;
`endif
        end else if (cpu_elig_i) begin
            win_o = OWN_CPU;
        end else if (dma_req_i) begin
            win_o = OWN_DMA;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
// Shares one synchronous data-RAM port between the CPU core and a DMA /
// display-fetch master. One access per cycle, read data one cycle later.
// Ports:
//   clk_i, reset_i            : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata_i   : CPU access (request held until completion)
//   cpu_rdata_o, cpu_rvalid_o : CPU load data, valid one cycle after grant
//   cpu_stall_o               : core Stall (freeze PC/regfile this cycle)
//   dma_req/we/lock/addr/wdata_i : DMA access, lock asks for a burst
//   dma_gnt_o                 : DMA access issued this cycle
//   dma_rdata_o, dma_rvalid_o : DMA read data, valid one cycle after grant
//   ram_en/we/addr/wdata_o    : RAM port (word address), ram_rdata_i back
// Build option: ARB_ROUND_ROBIN_EN (see dmem_arb_pick).
// ----------------------------------------------------------------------------
module dmem_arbiter import dmem_arb_pkg::*; #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_wdata_i,
    output logic [DW-1:0] cpu_rdata_o,
    output logic          cpu_rvalid_o,
    output logic          cpu_stall_o,
    input  logic          dma_req_i,
    input  logic          dma_we_i,
    input  logic          dma_lock_i,
    input  logic [AW-1:0] dma_addr_i,
    input  logic [DW-1:0] dma_wdata_i,
    output logic          dma_gnt_o,
    output logic [DW-1:0] dma_rdata_o,
    output logic          dma_rvalid_o,
    output logic          ram_en_o,
    output logic          ram_we_o,
    output logic [AW-3:0] ram_addr_o,
    output logic [DW-1:0] ram_wdata_o,
    input  logic [DW-1:0] ram_rdata_i
);

    localparam int            CW   = cnt_w(MAX_BURST);
    localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);

    logic          cpu_pend_q, cpu_pend_d;
    owner_t        rd_owner_q, rd_owner_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;
    owner_t        rr_last_q, rr_last_d;
    logic          lock_q, lock_d;

    owner_t pick_win, win;
    logic   cpu_elig, cpu_gnt, dma_gnt;

    // Byte-lane bits play no part in a word-addressed RAM.
    logic unused_lsb;
    assign unused_lsb = ^{cpu_addr_i[1:0], dma_addr_i[1:0]};

    assign cpu_elig = cpu_req_i & ~cpu_pend_q;

    dmem_arb_pick #(
        .MAX_BURST (MAX_BURST),
        .CW        (CW)
    ) u_pick (
        .cpu_elig_i  (cpu_elig),
        .dma_req_i   (dma_req_i),
        .lock_act_i  (lock_q & dma_lock_i),
        .burst_cnt_i (burst_cnt_q),
        .rr_last_i   (rr_last_q),
        .win_o       (pick_win)
    );

    // Nothing is issued to the RAM while reset is asserted.
    assign win     = reset_i ? OWN_NONE : pick_win;
    assign cpu_gnt = (win == OWN_CPU);
    assign dma_gnt = (win == OWN_DMA);

    always_comb begin
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        if (cpu_gnt) begin
            ram_en_o    = 1'b1;
            ram_we_o    = cpu_we_i;
            ram_addr_o  = cpu_addr_i[AW-1:2];
            ram_wdata_o = cpu_wdata_i;
        end else if (dma_gnt) begin
            ram_en_o    = 1'b1;
            ram_we_o    = dma_we_i;
            ram_addr_o  = dma_addr_i[AW-1:2];
            ram_wdata_o = dma_wdata_i;
        end
    end

    assign dma_gnt_o    = dma_gnt;
    assign cpu_rvalid_o = ~reset_i & (rd_owner_q == OWN_CPU);
    assign dma_rvalid_o = ~reset_i & (rd_owner_q == OWN_DMA);
    assign cpu_rdata_o  = cpu_rvalid_o ? ram_rdata_i : '0;
    assign dma_rdata_o  = dma_rvalid_o ? ram_rdata_i : '0;
    assign cpu_stall_o  = ~reset_i & cpu_req_i & ~(cpu_gnt & cpu_we_i) & ~cpu_rvalid_o;

    always_comb begin
        cpu_pend_d = cpu_gnt & ~cpu_we_i;
        rd_owner_d = OWN_NONE;
        if (cpu_gnt && !cpu_we_i)      rd_owner_d = OWN_CPU;
        else if (dma_gnt && !dma_we_i) rd_owner_d = OWN_DMA;
        lock_d      = dma_gnt & dma_lock_i;
        rr_last_d   = (win != OWN_NONE) ? win : rr_last_q;
        burst_cnt_d = burst_cnt_q;
        // Only DMA beats that actually starve an eligible CPU count toward the cap.
        if (cpu_gnt || !dma_lock_i)
            burst_cnt_d = '0;
        else if (dma_gnt && cpu_elig && (burst_cnt_q < MAXC))
            burst_cnt_d = burst_cnt_q + CW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cpu_pend_q  <= 1'b0;
            rd_owner_q  <= OWN_NONE;
            burst_cnt_q <= '0;
            rr_last_q   <= OWN_DMA;
            lock_q      <= 1'b0;
        end else begin
            cpu_pend_q  <= cpu_pend_d;
            rd_owner_q  <= rd_owner_d;
            burst_cnt_q <= burst_cnt_d;
            rr_last_q   <= rr_last_d;
            lock_q      <= lock_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed scenarios followed by constrained-random traffic, every cycle
// compared against a transaction-level model of the arbitration rules.
// ----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MB = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_rvalid, cpu_stall;
    logic          dma_req, dma_we, dma_lock;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata, dma_rdata;
    logic          dma_gnt, dma_rvalid;
    logic          ram_en, ram_we;
    logic [AW-3:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .cpu_req_i    (cpu_req),
        .cpu_we_i     (cpu_we),
        .cpu_addr_i   (cpu_addr),
        .cpu_wdata_i  (cpu_wdata),
        .cpu_rdata_o  (cpu_rdata),
        .cpu_rvalid_o (cpu_rvalid),
        .cpu_stall_o  (cpu_stall),
        .dma_req_i    (dma_req),
        .dma_we_i     (dma_we),
        .dma_lock_i   (dma_lock),
        .dma_addr_i   (dma_addr),
        .dma_wdata_i  (dma_wdata),
        .dma_gnt_o    (dma_gnt),
        .dma_rdata_o  (dma_rdata),
        .dma_rvalid_o (dma_rvalid),
        .ram_en_o     (ram_en),
        .ram_we_o     (ram_we),
        .ram_addr_o   (ram_addr),
        .ram_wdata_o  (ram_wdata),
        .ram_rdata_i  (ram_rdata)
    );

    int tests = 0;
    int fails = 0;

    // Model state: who has read data coming back (0 none, 1 cpu, 2 dma),
    // whether the last grant was a locked DMA beat, how many locked beats
    // have starved the CPU, and who was served last (1 cpu, 2 dma).
    int m_rd = 0, m_run = 0, m_last = 2;
    bit m_locked = 0;

    // Per-cycle expectations and observed snapshots.
    int e_win;
    bit e_rv;
    logic          s_en, s_we, s_cstall, s_crv, s_dgnt;
    logic [AW-3:0] s_addr;
    logic [DW-1:0] s_wdata, s_crd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 with inputs already driven; returns at next posedge+1.
    task automatic cycle();
        bit cpu_ok, e_stall, e_drv, e_we;
        logic [AW-3:0] e_addr;
        logic [DW-1:0] e_wd;
        cpu_ok = cpu_req && (m_rd != 1);
        if (reset)
            e_win = 0;
        else if (dma_req && dma_lock && m_locked && m_run < MB)
            e_win = 2;
        else if (cpu_ok && dma_req)
`ifdef ARB_ROUND_ROBIN_EN
            e_win = (m_last == 1) ? 2 : 1;
`else
            e_win = 1;
`endif
        else if (cpu_ok)
            e_win = 1;
        else if (dma_req)
            e_win = 2;
        else
            e_win = 0;
        e_rv  = !reset && m_rd == 1;
        e_drv = !reset && m_rd == 2;
        e_we = 0; e_addr = '0; e_wd = '0;
        if (e_win == 1) begin e_we = cpu_we; e_addr = cpu_addr[AW-1:2]; e_wd = cpu_wdata; end
        if (e_win == 2) begin e_we = dma_we; e_addr = dma_addr[AW-1:2]; e_wd = dma_wdata; end
        e_stall = !reset && cpu_req && !(e_win == 1 && cpu_we) && !e_rv;
        #4;
        s_en = ram_en; s_we = ram_we; s_addr = ram_addr; s_wdata = ram_wdata;
        s_cstall = cpu_stall; s_crv = cpu_rvalid; s_crd = cpu_rdata; s_dgnt = dma_gnt;
        chk("ram_en",     64'(ram_en),     64'(e_win != 0));
        chk("ram_we",     64'(ram_we),     64'(e_we));
        chk("ram_addr",   64'(ram_addr),   64'(e_addr));
        chk("ram_wdata",  64'(ram_wdata),  64'(e_wd));
        chk("dma_gnt",    64'(dma_gnt),    64'(e_win == 2));
        chk("cpu_stall",  64'(cpu_stall),  64'(e_stall));
        chk("cpu_rvalid", 64'(cpu_rvalid), 64'(e_rv));
        chk("cpu_rdata",  64'(cpu_rdata),  64'(e_rv ? ram_rdata : '0));
        chk("dma_rvalid", 64'(dma_rvalid), 64'(e_drv));
        chk("dma_rdata",  64'(dma_rdata),  64'(e_drv ? ram_rdata : '0));
        @(posedge clk);
        if (reset) begin
            m_rd = 0; m_run = 0; m_last = 2; m_locked = 0;
        end else begin
            if (e_win == 1 && !cpu_we)      m_rd = 1;
            else if (e_win == 2 && !dma_we) m_rd = 2;
            else                            m_rd = 0;
            m_locked = (e_win == 2) && dma_lock;
            if (e_win == 1 || !dma_lock)                   m_run = 0;
            else if (e_win == 2 && cpu_ok && m_run < MB)   m_run++;
            if (e_win != 0) m_last = e_win;
        end
        #1;
    endtask

    initial begin
        int dcnt, waitg;
        bit cdone, cact;
        reset = 1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_lock = 0; dma_addr = '0; dma_wdata = '0;
        ram_rdata = '0;
        @(posedge clk); #1;

        // 1: reset held with both masters requesting
        cpu_req = 1; dma_req = 1; cpu_addr = 32'h44; dma_addr = 32'h88;
        repeat (3) begin
            ram_rdata = $urandom;
            cycle();
            chk("t1_ram_en", 64'(s_en), 64'(0));
            chk("t1_stall",  64'(s_cstall), 64'(0));
            chk("t1_dgnt",   64'(s_dgnt), 64'(0));
        end
        reset = 0; cpu_req = 0; dma_req = 0;

        // 2: lone CPU load
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
        cycle();
        chk("t2_c0_en",    64'(s_en), 64'(1));
        chk("t2_c0_addr",  64'(s_addr), 64'(32'h40));
        chk("t2_c0_stall", 64'(s_cstall), 64'(1));
        ram_rdata = 32'hDEADBEEF;
        cycle();
        chk("t2_c1_rvalid", 64'(s_crv), 64'(1));
        chk("t2_c1_rdata",  64'(s_crd), 64'(32'hDEADBEEF));
        chk("t2_c1_stall",  64'(s_cstall), 64'(0));

        // 3: lone CPU store
        cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'h55;
        cycle();
        chk("t3_we",    64'(s_we), 64'(1));
        chk("t3_addr",  64'(s_addr), 64'(32'h08));
        chk("t3_wdata", 64'(s_wdata), 64'(32'h55));
        chk("t3_stall", 64'(s_cstall), 64'(0));

        // 4: unlocked conflict right after a CPU grant
        cpu_we = 0; cpu_addr = 32'h0; dma_req = 1; dma_we = 0; dma_addr = 32'h400;
        cycle();
`ifdef ARB_ROUND_ROBIN_EN
        chk("t4_dgnt",  64'(s_dgnt), 64'(1));
        chk("t4_stall", 64'(s_cstall), 64'(1));
`else
        chk("t4_dgnt",  64'(s_dgnt), 64'(0));
        chk("t4_en",    64'(s_en), 64'(1));
`endif
        dma_req = 0;
        cdone = 0;
        for (int i = 0; i < 6 && !cdone; i++) begin
            ram_rdata = $urandom;
            cycle();
            if (e_rv) cdone = 1;
        end
        cpu_req = 0;
        cycle();

        // 5: 12-beat locked DMA burst with a CPU load arriving after beat 1
        dcnt = 0; waitg = 0; cdone = 0; cact = 0;
        dma_lock = 1; dma_we = 0; cpu_we = 0; cpu_addr = 32'h200;
        for (int i = 0; i < 40 && (dcnt < 12 || !cdone); i++) begin
            bit waiting;
            dma_req = (dcnt < 12); dma_addr = $urandom; ram_rdata = $urandom;
            cpu_req = (i >= 1) && !cdone;
            waiting = cpu_req && !cact;
            cycle();
            if (s_dgnt) begin
                dcnt++;
                if (waiting) waitg++;
            end
            if (e_win == 1) cact = 1;
            if (e_rv) cdone = 1;
        end
        chk("t5_dma_while_cpu_waits", 64'(waitg), 64'(MB));
        chk("t5_dma_total",           64'(dcnt),  64'(12));
        chk("t5_cpu_done",            64'(cdone), 64'(1));
        dma_req = 0; dma_lock = 0; cpu_req = 0;
        cycle();

        // 6: reset the cycle after a CPU load grant
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h300;
        cycle();
        reset = 1;
        cycle();
        chk("t6_rvalid_dropped", 64'(s_crv), 64'(0));
        reset = 0; cpu_req = 0;
        cycle();
        cpu_req = 1;
        cycle();
        chk("t6_regrant_en",    64'(s_en), 64'(1));
        chk("t6_regrant_stall", 64'(s_cstall), 64'(1));
        cycle();
        cpu_req = 0;

        // Random traffic
        cact = 0;
        for (int i = 0; i < 400; i++) begin
            if (!cact && $urandom_range(0, 2) == 0) begin
                cact = 1; cpu_we = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
            end
            cpu_req   = cact;
            dma_req   = ($urandom_range(0, 3) != 0);
            dma_we    = 1'($urandom);
            if ($urandom_range(0, 7) == 0) dma_lock = ~dma_lock;
            dma_addr  = $urandom; dma_wdata = $urandom; ram_rdata = $urandom;
            reset     = ($urandom_range(0, 63) == 0);
            cycle();
            if (cact && (reset || (e_win == 1 && cpu_we) || e_rv)) cact = 0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
